// File: rtl/multicycle_control.sv
// Multi-cycle FSM sequencer for the MIPS-subset datapath with a memory wait timeout.
// Define MC_ADDI_EN to build the addi states (ADDI_EXEC/ADDI_WB).
module multicycle_control #(
  parameter int unsigned MEM_WAIT_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_fault,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_EXEC      = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic op_lw, op_sw, op_r, op_beq, op_bne, op_j;
  logic fn_ok, is_mem, is_r, is_br;
  logic wait_hit;

  assign op_lw  = (opcode == 6'b100011);
  assign op_sw  = (opcode == 6'b101011);
  assign op_r   = (opcode == 6'b000000);
  assign op_beq = (opcode == 6'b000100);
  assign op_bne = (opcode == 6'b000101);
  assign op_j   = (opcode == 6'b000010);

  assign fn_ok = (funct == 6'b100000) |
                 (funct == 6'b100010) |
                 (funct == 6'b100100) |
                 (funct == 6'b100101) |
                 (funct == 6'b101010);

  assign is_mem = op_lw | op_sw;
  assign is_r   = op_r & fn_ok;
  assign is_br  = op_beq | op_bne;

`ifdef MC_ADDI_EN
  logic op_addi;
  assign op_addi = (opcode == 6'b001000);
`endif

  // Timeout fires on the last allowed cycle only if memory is still busy
  assign wait_hit = (cnt_q == WAIT_LAST) & ~mem_ready;

  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    ir_write    = 1'b0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    mem_fault   = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_read    = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_hit) begin
          mem_fault = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
        unique case (1'b1)
          is_mem:  state_d = S_MEM_ADDR;
          is_r:    state_d = S_EXEC;
          is_br:   state_d = S_BRANCH;
          op_j:    state_d = S_JUMP;
`ifdef MC_ADDI_EN
          op_addi: state_d = S_ADDI_EXEC;
`endif
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_d     = op_lw ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (wait_hit) begin
          mem_fault = 1'b1;
          state_d   = S_FETCH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (wait_hit) begin
          mem_fault = 1'b1;
          state_d   = S_FETCH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        unique case (1'b1)
          (funct == 6'b100010): alu_control = ALU_SUB;
          (funct == 6'b100100): alu_control = ALU_AND;
          (funct == 6'b100101): alu_control = ALU_OR;
          (funct == 6'b101010): alu_control = ALU_SLT;
          default:              alu_control = ALU_ADD;
        endcase
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_write    = (op_beq & zero) | (op_bne & ~zero);
        instr_done  = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`ifdef MC_ADDI_EN
      S_ADDI_EXEC: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_d     = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control (MEM_WAIT_MAX = 16).
// Each step drives inputs at negedge, queues expected outputs, then compares.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic       instr_done;
  logic       illegal;
  logic       mem_fault;
  logic [3:0] state;

  multicycle_control #(.MEM_WAIT_MAX(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .ir_write    (ir_write),
    .i_or_d      (i_or_d),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .instr_done  (instr_done),
    .illegal     (illegal),
    .mem_fault   (mem_fault),
    .state       (state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       instr_done;
    logic       illegal;
    logic       mem_fault;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic [5:0] fn_tab[5]  = '{6'b100000, 6'b100010, 6'b100100,
                             6'b100101, 6'b101010};
  logic [2:0] alu_tab[5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t sample();
    exp_t g;
    g.st          = state;
    g.pc_write    = pc_write;
    g.pc_src      = pc_src;
    g.ir_write    = ir_write;
    g.i_or_d      = i_or_d;
    g.mem_read    = mem_read;
    g.mem_write   = mem_write;
    g.reg_dst     = reg_dst;
    g.mem_to_reg  = mem_to_reg;
    g.reg_write   = reg_write;
    g.alu_src_a   = alu_src_a;
    g.alu_src_b   = alu_src_b;
    g.alu_control = alu_control;
    g.instr_done  = instr_done;
    g.illegal     = illegal;
    g.mem_fault   = mem_fault;
    return g;
  endfunction

  function automatic exp_t e_fetch(logic rdy, logic flt);
    exp_t e = '0;
    e.st = 4'd0; e.mem_read = 1'b1;
    e.alu_src_b = 2'b01; e.alu_control = 3'b010;
    e.ir_write = rdy; e.pc_write = rdy; e.mem_fault = flt;
    return e;
  endfunction

  function automatic exp_t e_decode(logic ill);
    exp_t e = '0;
    e.st = 4'd1; e.alu_src_b = 2'b11;
    e.alu_control = 3'b010; e.illegal = ill;
    return e;
  endfunction

  function automatic exp_t e_memaddr();
    exp_t e = '0;
    e.st = 4'd2; e.alu_src_a = 1'b1;
    e.alu_src_b = 2'b10; e.alu_control = 3'b010;
    return e;
  endfunction

  function automatic exp_t e_memrd(logic flt);
    exp_t e = '0;
    e.st = 4'd3; e.mem_read = 1'b1; e.i_or_d = 1'b1;
    e.mem_fault = flt;
    return e;
  endfunction

  function automatic exp_t e_memwb();
    exp_t e = '0;
    e.st = 4'd4; e.reg_write = 1'b1;
    e.mem_to_reg = 1'b1; e.instr_done = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_memwr(logic rdy, logic flt);
    exp_t e = '0;
    e.st = 4'd5; e.mem_write = 1'b1; e.i_or_d = 1'b1;
    e.instr_done = rdy; e.mem_fault = flt;
    return e;
  endfunction

  function automatic exp_t e_exec(logic [2:0] alu);
    exp_t e = '0;
    e.st = 4'd6; e.alu_src_a = 1'b1; e.alu_control = alu;
    return e;
  endfunction

  function automatic exp_t e_aluwb();
    exp_t e = '0;
    e.st = 4'd7; e.reg_write = 1'b1;
    e.reg_dst = 1'b1; e.instr_done = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_branch(logic pw);
    exp_t e = '0;
    e.st = 4'd8; e.alu_src_a = 1'b1; e.alu_control = 3'b110;
    e.pc_src = 2'b01; e.pc_write = pw; e.instr_done = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_jump();
    exp_t e = '0;
    e.st = 4'd9; e.pc_src = 2'b10;
    e.pc_write = 1'b1; e.instr_done = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_addi_ex();
    exp_t e = '0;
    e.st = 4'd10; e.alu_src_a = 1'b1;
    e.alu_src_b = 2'b10; e.alu_control = 3'b010;
    return e;
  endfunction

  function automatic exp_t e_addi_wb();
    exp_t e = '0;
    e.st = 4'd11; e.reg_write = 1'b1; e.instr_done = 1'b1;
    return e;
  endfunction

  task automatic check_now(input exp_t e, input string tag);
    exp_t got;
    exp_t ex;
    exp_q.push_back(e);
    #2;
    got = sample();
    ex  = exp_q.pop_front();
    n_checks++;
    assert (got === ex) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, ex);
    end
  endtask

  task automatic step(input exp_t e, input logic [5:0] op,
                      input logic [5:0] fn, input logic z,
                      input logic rdy, input string tag);
    @(negedge clk);
    opcode    = op;
    funct     = fn;
    zero      = z;
    mem_ready = rdy;
    check_now(e, tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = 6'd0;
    funct     = 6'd0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    check_now(e_fetch(1'b0, 1'b0), "reset");
    @(negedge clk);
    rst_n = 1'b1;

    // R-type: 4 cycles each, ALU op by funct
    for (int i = 0; i < 5; i++) begin
      step(e_fetch(1'b1, 1'b0), OP_R, fn_tab[i], 1'b0, 1'b1,
           $sformatf("r%0d_fetch", i));
      step(e_decode(1'b0), OP_R, fn_tab[i], 1'b0, 1'b1,
           $sformatf("r%0d_decode", i));
      step(e_exec(alu_tab[i]), OP_R, fn_tab[i], 1'b0, 1'b1,
           $sformatf("r%0d_exec", i));
      step(e_aluwb(), OP_R, fn_tab[i], 1'b0, 1'b1,
           $sformatf("r%0d_wb", i));
    end

    // lw with two wait cycles: 7 cycles
    step(e_fetch(1'b1, 1'b0), OP_LW, 6'd0, 1'b0, 1'b1, "lw_fetch");
    step(e_decode(1'b0), OP_LW, 6'd0, 1'b0, 1'b1, "lw_decode");
    step(e_memaddr(), OP_LW, 6'd0, 1'b0, 1'b1, "lw_addr");
    step(e_memrd(1'b0), OP_LW, 6'd0, 1'b0, 1'b0, "lw_wait1");
    step(e_memrd(1'b0), OP_LW, 6'd0, 1'b0, 1'b0, "lw_wait2");
    step(e_memrd(1'b0), OP_LW, 6'd0, 1'b0, 1'b1, "lw_rd");
    step(e_memwb(), OP_LW, 6'd0, 1'b0, 1'b1, "lw_wb");

    // sw zero-wait: 4 cycles
    step(e_fetch(1'b1, 1'b0), OP_SW, 6'd0, 1'b0, 1'b1, "sw_fetch");
    step(e_decode(1'b0), OP_SW, 6'd0, 1'b0, 1'b1, "sw_decode");
    step(e_memaddr(), OP_SW, 6'd0, 1'b0, 1'b1, "sw_addr");
    step(e_memwr(1'b1, 1'b0), OP_SW, 6'd0, 1'b0, 1'b1, "sw_wr");

    // Branches: all four opcode/zero combinations
    step(e_fetch(1'b1, 1'b0), OP_BEQ, 6'd0, 1'b1, 1'b1, "beq1_fetch");
    step(e_decode(1'b0), OP_BEQ, 6'd0, 1'b1, 1'b1, "beq1_decode");
    step(e_branch(1'b1), OP_BEQ, 6'd0, 1'b1, 1'b1, "beq_z1");
    step(e_fetch(1'b1, 1'b0), OP_BNE, 6'd0, 1'b1, 1'b1, "bne1_fetch");
    step(e_decode(1'b0), OP_BNE, 6'd0, 1'b1, 1'b1, "bne1_decode");
    step(e_branch(1'b0), OP_BNE, 6'd0, 1'b1, 1'b1, "bne_z1");
    step(e_fetch(1'b1, 1'b0), OP_BEQ, 6'd0, 1'b0, 1'b1, "beq0_fetch");
    step(e_decode(1'b0), OP_BEQ, 6'd0, 1'b0, 1'b1, "beq0_decode");
    step(e_branch(1'b0), OP_BEQ, 6'd0, 1'b0, 1'b1, "beq_z0");
    step(e_fetch(1'b1, 1'b0), OP_BNE, 6'd0, 1'b0, 1'b1, "bne0_fetch");
    step(e_decode(1'b0), OP_BNE, 6'd0, 1'b0, 1'b1, "bne0_decode");
    step(e_branch(1'b1), OP_BNE, 6'd0, 1'b0, 1'b1, "bne_z0");

    // Jump
    step(e_fetch(1'b1, 1'b0), OP_J, 6'd0, 1'b0, 1'b1, "j_fetch");
    step(e_decode(1'b0), OP_J, 6'd0, 1'b0, 1'b1, "j_decode");
    step(e_jump(), OP_J, 6'd0, 1'b0, 1'b1, "j_jump");

    // sw timeout: fault on 16th MEM_WR cycle, no instr_done
    step(e_fetch(1'b1, 1'b0), OP_SW, 6'd0, 1'b0, 1'b1, "swto_fetch");
    step(e_decode(1'b0), OP_SW, 6'd0, 1'b0, 1'b1, "swto_decode");
    step(e_memaddr(), OP_SW, 6'd0, 1'b0, 1'b1, "swto_addr");
    for (int i = 1; i <= 15; i++)
      step(e_memwr(1'b0, 1'b0), OP_SW, 6'd0, 1'b0, 1'b0,
           $sformatf("swto_wait%0d", i));
    step(e_memwr(1'b0, 1'b1), OP_SW, 6'd0, 1'b0, 1'b0, "swto_fault");

    // FETCH timeout retries with a fresh counter
    for (int i = 1; i <= 15; i++)
      step(e_fetch(1'b0, 1'b0), OP_J, 6'd0, 1'b0, 1'b0,
           $sformatf("fto_wait%0d", i));
    step(e_fetch(1'b0, 1'b1), OP_J, 6'd0, 1'b0, 1'b0, "fto_fault");
    for (int i = 1; i <= 15; i++)
      step(e_fetch(1'b0, 1'b0), OP_J, 6'd0, 1'b0, 1'b0,
           $sformatf("fto_retry%0d", i));
    step(e_fetch(1'b1, 1'b0), OP_J, 6'd0, 1'b0, 1'b1, "fto_done");
    step(e_decode(1'b0), OP_J, 6'd0, 1'b0, 1'b1, "fto_decode");
    step(e_jump(), OP_J, 6'd0, 1'b0, 1'b1, "fto_jump");

    // lw with ready on the 16th MEM_RD cycle: completes, no fault
    step(e_fetch(1'b1, 1'b0), OP_LW, 6'd0, 1'b0, 1'b1, "lwl_fetch");
    step(e_decode(1'b0), OP_LW, 6'd0, 1'b0, 1'b1, "lwl_decode");
    step(e_memaddr(), OP_LW, 6'd0, 1'b0, 1'b1, "lwl_addr");
    for (int i = 1; i <= 15; i++)
      step(e_memrd(1'b0), OP_LW, 6'd0, 1'b0, 1'b0,
           $sformatf("lwl_wait%0d", i));
    step(e_memrd(1'b0), OP_LW, 6'd0, 1'b0, 1'b1, "lwl_last");
    step(e_memwb(), OP_LW, 6'd0, 1'b0, 1'b1, "lwl_wb");

    // addi: built or illegal depending on configuration
    step(e_fetch(1'b1, 1'b0), OP_ADDI, 6'd0, 1'b0, 1'b1, "addi_fetch");
`ifdef MC_ADDI_EN
    step(e_decode(1'b0), OP_ADDI, 6'd0, 1'b0, 1'b1, "addi_decode");
    step(e_addi_ex(), OP_ADDI, 6'd0, 1'b0, 1'b1, "addi_exec");
    step(e_addi_wb(), OP_ADDI, 6'd0, 1'b0, 1'b1, "addi_wb");
`else
    step(e_decode(1'b1), OP_ADDI, 6'd0, 1'b0, 1'b1, "addi_illegal");
`endif

    // Unsupported opcode and unsupported R-type funct
    step(e_fetch(1'b1, 1'b0), 6'b111111, 6'd0, 1'b0, 1'b1, "ill_fetch");
    step(e_decode(1'b1), 6'b111111, 6'd0, 1'b0, 1'b1, "ill_op");
    step(e_fetch(1'b1, 1'b0), OP_R, 6'b111111, 1'b0, 1'b1, "illf_fetch");
    step(e_decode(1'b1), OP_R, 6'b111111, 1'b0, 1'b1, "ill_funct");

    // Asynchronous reset in the middle of EXEC
    step(e_fetch(1'b1, 1'b0), OP_R, 6'b100000, 1'b0, 1'b1, "rst_fetch");
    step(e_decode(1'b0), OP_R, 6'b100000, 1'b0, 1'b1, "rst_decode");
    step(e_exec(3'b010), OP_R, 6'b100000, 1'b0, 1'b1, "rst_exec");
    #1;
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    check_now(e_fetch(1'b0, 1'b0), "rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    step(e_fetch(1'b1, 1'b0), OP_J, 6'd0, 1'b0, 1'b1, "post_fetch");
    step(e_decode(1'b0), OP_J, 6'd0, 1'b0, 1'b1, "post_decode");
    step(e_jump(), OP_J, 6'd0, 1'b0, 1'b1, "post_jump");

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
